// File: rtl/rt8_pkg.sv
// Shared constants, state type and error-flag helper for the rt8 approximate-tree decoder.
package rt8_pkg;

  localparam int APX_ERR_WEIGHT = 4;
  localparam int EXACT_MAX      = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } rt8_dec_state_t;

  // u_err is {U0,U1,U2}; U2 cannot err together with either first-level compressor.
  function automatic logic illegal_err(input logic [2:0] u_err);
    return u_err[0] & (u_err[2] | u_err[1]);
  endfunction

endpackage

// File: rtl/rt8_sample_decode.sv
// Combinational per-sample decode: approximate count, error magnitude and corrected count.
module rt8_sample_decode
  import rt8_pkg::*;
(
  input  logic       sum,
  input  logic       carry,
  input  logic       cout1,
  input  logic       cout2,
  input  logic [2:0] u_err,
  output logic [3:0] apx,
  output logic [3:0] exact,
  output logic [3:0] err_mag,
  output logic       illegal
);

  logic [1:0] n_pairs;
  logic [1:0] n_err;

  assign illegal = illegal_err(u_err);

  always_comb begin
    n_pairs = {1'b0, carry} + {1'b0, cout1} + {1'b0, cout2};
    n_err   = {1'b0, u_err[0]} + {1'b0, u_err[1]} + {1'b0, u_err[2]};
    apx     = {1'b0, n_pairs, sum};
    err_mag = 4'(APX_ERR_WEIGHT * int'(n_err));
    // Legal samples top out at 15, so only the impossible combinations need clamping.
    exact   = illegal ? 4'(EXACT_MAX) : apx + err_mag;
  end

endmodule

// File: rtl/rt8_apx_decode.sv
// rt8 receive stage: registered per-sample decode with backpressure and per-frame statistics.
module rt8_apx_decode
  import rt8_pkg::*;
#(
  parameter int FRAME_LEN = 16,
  parameter int SUM_W     = $clog2(10 * FRAME_LEN + 1),
  parameter int CNT_W     = $clog2(FRAME_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sum,
  input  logic             in_carry,
  input  logic             in_cout1,
  input  logic             in_cout2,
  input  logic [2:0]       in_u_err,
  input  logic             frame_start,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_apx,
  output logic [3:0]       out_exact,
  output logic [3:0]       out_err_mag,
  output logic             out_illegal,
  output logic             frame_done,
  output logic [SUM_W-1:0] frame_exact_sum,
  output logic [SUM_W-1:0] frame_apx_sum,
  output logic [CNT_W-1:0] frame_err_cnt,
  output logic             illegal_sticky
);

  logic       accept;
  logic [3:0] dec_apx;
  logic [3:0] dec_exact;
  logic [3:0] dec_err_mag;
  logic       dec_illegal;

  rt8_dec_state_t   state_q, state_d;
  logic             acc_clear;
  logic             acc_add;
  logic [SUM_W-1:0] exact_sum_d;
  logic [SUM_W-1:0] apx_sum_d;
  logic [CNT_W-1:0] err_cnt_d;
  logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d;

  assign in_ready   = ~out_valid | out_ready;
  assign accept     = in_valid & in_ready;
  assign frame_done = (state_q == DONE);

  rt8_sample_decode u_dec (
    .sum     (in_sum),
    .carry   (in_carry),
    .cout1   (in_cout1),
    .cout2   (in_cout2),
    .u_err   (in_u_err),
    .apx     (dec_apx),
    .exact   (dec_exact),
    .err_mag (dec_err_mag),
    .illegal (dec_illegal)
  );

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d   = state_q;
    acc_clear = 1'b0;
    acc_add   = 1'b0;
    case (state_q)
      IDLE: begin
        if (frame_start) begin
          state_d   = RUN;
          acc_clear = 1'b1;
        end
      end
      RUN: begin
        acc_clear = frame_start;
        acc_add   = accept;
      end
      DONE: begin
        state_d   = frame_start ? RUN : IDLE;
        acc_clear = frame_start;
        acc_add   = accept & frame_start;
      end
      default: state_d = IDLE;
    endcase

    exact_sum_d  = acc_clear ? '0 : frame_exact_sum;
    apx_sum_d    = acc_clear ? '0 : frame_apx_sum;
    err_cnt_d    = acc_clear ? '0 : frame_err_cnt;
    sample_cnt_d = acc_clear ? '0 : sample_cnt_q;
    if (acc_add) begin
      exact_sum_d  = exact_sum_d + SUM_W'(dec_exact);
      apx_sum_d    = apx_sum_d + SUM_W'(dec_apx);
      err_cnt_d    = err_cnt_d + CNT_W'(|in_u_err);
      sample_cnt_d = sample_cnt_d + CNT_W'(1);
    end
    // A restart that already carries the last sample of a one-sample frame also completes it.
    if (acc_add && sample_cnt_d == CNT_W'(FRAME_LEN)) state_d = DONE;
  end

  always_ff @(posedge clk) begin
    // NOTE: state updates use non-blocking assignments so all registers see pre-edge values.
    if (!rst_n) begin
      state_q         <= IDLE;
      sample_cnt_q    <= '0;
      frame_exact_sum <= '0;
      frame_apx_sum   <= '0;
      frame_err_cnt   <= '0;
      out_valid       <= 1'b0;
      out_apx         <= '0;
      out_exact       <= '0;
      out_err_mag     <= '0;
      out_illegal     <= 1'b0;
      illegal_sticky  <= 1'b0;
    end else begin
      state_q         <= state_d;
      sample_cnt_q    <= sample_cnt_d;
      frame_exact_sum <= exact_sum_d;
      frame_apx_sum   <= apx_sum_d;
      frame_err_cnt   <= err_cnt_d;
      if (accept) begin
        out_valid   <= 1'b1;
        out_apx     <= dec_apx;
        out_exact   <= dec_exact;
        out_err_mag <= dec_err_mag;
        out_illegal <= dec_illegal;
        if (dec_illegal) illegal_sticky <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rt8_apx_decode.sv
// Self-checking bench for rt8_apx_decode: directed literal checks plus randomized traffic vs a behavioural model.
module tb_rt8_apx_decode;

  localparam int FRAME_LEN = 4;
  localparam int SUM_W     = $clog2(10 * FRAME_LEN + 1);
  localparam int CNT_W     = $clog2(FRAME_LEN + 1);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic             in_sum;
  logic             in_carry;
  logic             in_cout1;
  logic             in_cout2;
  logic [2:0]       in_u_err;
  logic             frame_start;
  logic             out_valid;
  logic             out_ready;
  logic [3:0]       out_apx;
  logic [3:0]       out_exact;
  logic [3:0]       out_err_mag;
  logic             out_illegal;
  logic             frame_done;
  logic [SUM_W-1:0] frame_exact_sum;
  logic [SUM_W-1:0] frame_apx_sum;
  logic [CNT_W-1:0] frame_err_cnt;
  logic             illegal_sticky;

  int n_tests = 0;
  int n_fail  = 0;

  rt8_apx_decode #(.FRAME_LEN(FRAME_LEN)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_sum          (in_sum),
    .in_carry        (in_carry),
    .in_cout1        (in_cout1),
    .in_cout2        (in_cout2),
    .in_u_err        (in_u_err),
    .frame_start     (frame_start),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_apx         (out_apx),
    .out_exact       (out_exact),
    .out_err_mag     (out_err_mag),
    .out_illegal     (out_illegal),
    .frame_done      (frame_done),
    .frame_exact_sum (frame_exact_sum),
    .frame_apx_sum   (frame_apx_sum),
    .frame_err_cnt   (frame_err_cnt),
    .illegal_sticky  (illegal_sticky)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks the output slot and the frame in transaction terms.
  bit m_out_valid, m_ill, m_sticky, m_in_frame, m_done;
  int m_apx, m_exact, m_err;
  int m_cnt, m_esum, m_asum, m_ecnt;

  always @(posedge clk) begin
    bit acc, counted, live, s_ill;
    int s_apx, s_err, s_exact;
    if (!rst_n) begin
      m_out_valid = 0; m_ill = 0; m_sticky = 0; m_in_frame = 0; m_done = 0;
      m_apx = 0; m_exact = 0; m_err = 0;
      m_cnt = 0; m_esum = 0; m_asum = 0; m_ecnt = 0;
    end else begin
      acc     = in_valid && (!m_out_valid || out_ready);
      s_apx   = int'(in_sum) + 2 * (int'(in_carry) + int'(in_cout1) + int'(in_cout2));
      s_err   = 4 * $countones(in_u_err);
      s_ill   = in_u_err[0] && (in_u_err[1] || in_u_err[2]);
      s_exact = s_ill ? 10 : s_apx + s_err;

      live = m_in_frame || m_done;
      if (frame_start) begin
        m_cnt = 0; m_esum = 0; m_asum = 0; m_ecnt = 0;
        counted    = acc && live;
        m_in_frame = 1;
      end else begin
        counted = acc && m_in_frame;
      end
      m_done = 0;
      if (counted) begin
        m_cnt++;
        m_esum += s_exact;
        m_asum += s_apx;
        if (in_u_err != 3'b000) m_ecnt++;
        if (m_cnt == FRAME_LEN) begin
          m_in_frame = 0;
          m_done     = 1;
        end
      end

      if (acc) begin
        m_out_valid = 1;
        m_apx = s_apx; m_exact = s_exact; m_err = s_err; m_ill = s_ill;
        if (s_ill) m_sticky = 1;
      end else if (out_ready) begin
        m_out_valid = 0;
      end
    end
  end

  always @(negedge clk) begin
    check("out_valid", int'(out_valid), int'(m_out_valid));
    check("in_ready", int'(in_ready), int'(!m_out_valid || out_ready));
    check("frame_done", int'(frame_done), int'(m_done));
    check("illegal_sticky", int'(illegal_sticky), int'(m_sticky));
    if (m_out_valid) begin
      check("out_apx", int'(out_apx), m_apx);
      check("out_exact", int'(out_exact), m_exact);
      check("out_err_mag", int'(out_err_mag), m_err);
      check("out_illegal", int'(out_illegal), int'(m_ill));
    end
    if (m_done) begin
      check("frame_exact_sum", int'(frame_exact_sum), m_esum);
      check("frame_apx_sum", int'(frame_apx_sum), m_asum);
      check("frame_err_cnt", int'(frame_err_cnt), m_ecnt);
    end
  end

  task automatic put(input bit s, input bit c, input bit c1, input bit c2,
                     input bit [2:0] u, input bit fs);
    in_valid = 1'b1; in_sum = s; in_carry = c; in_cout1 = c1; in_cout2 = c2;
    in_u_err = u; frame_start = fs;
    @(posedge clk); #1;
    in_valid = 1'b0; frame_start = 1'b0;
  endtask

  task automatic idle(input bit fs);
    in_valid = 1'b0; frame_start = fs;
    @(posedge clk); #1;
    frame_start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_sum = 1'b0; in_carry = 1'b0; in_cout1 = 1'b0;
    in_cout2 = 1'b0; in_u_err = 3'b000; frame_start = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("rst out_valid", int'(out_valid), 0);
    check("rst in_ready", int'(in_ready), 1);
    check("rst frame_done", int'(frame_done), 0);
    check("rst exact_sum", int'(frame_exact_sum), 0);

    put(1, 1, 1, 0, 3'b000, 0);
    check("basic apx", int'(out_apx), 5);
    check("basic exact", int'(out_exact), 5);
    check("basic err_mag", int'(out_err_mag), 0);

    put(0, 1, 0, 0, 3'b110, 0);
    check("ones apx", int'(out_apx), 2);
    check("ones err_mag", int'(out_err_mag), 8);
    check("ones exact", int'(out_exact), 10);
    check("ones illegal", int'(out_illegal), 0);

    put(1, 0, 0, 0, 3'b101, 0);
    check("illegal flag", int'(out_illegal), 1);
    check("illegal exact", int'(out_exact), 10);
    check("illegal sticky", int'(illegal_sticky), 1);

    // Frame of exact 3, 7, 10, 0 with two erroring samples.
    idle(1);
    put(1, 1, 0, 0, 3'b000, 0);
    put(1, 1, 0, 0, 3'b010, 0);
    put(0, 1, 1, 1, 3'b100, 0);
    check("frame not yet done", int'(frame_done), 0);
    put(0, 0, 0, 0, 3'b000, 0);
    check("frame done", int'(frame_done), 1);
    check("frame exact_sum", int'(frame_exact_sum), 20);
    check("frame apx_sum", int'(frame_apx_sum), 12);
    check("frame err_cnt", int'(frame_err_cnt), 2);
    idle(0);
    check("done one cycle", int'(frame_done), 0);
    check("sum held", int'(frame_exact_sum), 20);
    check("sticky held", int'(illegal_sticky), 1);

    // Backpressure: result held, input stalled, nothing lost.
    idle(1);
    out_ready = 1'b0;
    in_valid = 1'b1; in_sum = 1; in_carry = 1; in_cout1 = 0; in_cout2 = 0; in_u_err = 3'b000;
    @(posedge clk); #1;
    in_cout1 = 1;
    for (int i = 0; i < 3; i++) begin
      check("bp in_ready low", int'(in_ready), 0);
      check("bp out held", int'(out_exact), 3);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp released exact", int'(out_exact), 5);
    put(0, 0, 0, 0, 3'b000, 0);
    put(0, 0, 0, 0, 3'b000, 0);
    check("bp frame done", int'(frame_done), 1);
    check("bp frame sum", int'(frame_exact_sum), 8);

    // Restart after two samples: the restart sample becomes the first of the frame.
    idle(1);
    put(1, 0, 0, 0, 3'b000, 0);
    put(1, 0, 0, 0, 3'b000, 0);
    put(0, 1, 0, 0, 3'b000, 1);
    check("restart no done", int'(frame_done), 0);
    put(1, 0, 0, 0, 3'b000, 0);
    put(1, 0, 0, 0, 3'b000, 0);
    check("restart count", int'(frame_done), 0);
    put(1, 0, 0, 0, 3'b000, 0);
    check("restart done", int'(frame_done), 1);
    check("restart sum", int'(frame_exact_sum), 5);

    // Reset mid-frame clears everything and yields no frame_done.
    idle(1);
    put(1, 1, 0, 0, 3'b000, 0);
    put(1, 1, 0, 0, 3'b000, 0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("mid rst out_valid", int'(out_valid), 0);
    check("mid rst out_exact", int'(out_exact), 0);
    check("mid rst sticky", int'(illegal_sticky), 0);
    check("mid rst frame_done", int'(frame_done), 0);
    check("mid rst sum", int'(frame_exact_sum), 0);
    check("mid rst err_cnt", int'(frame_err_cnt), 0);
    rst_n = 1'b1;
    put(1, 1, 0, 0, 3'b000, 0);
    put(1, 1, 0, 0, 3'b000, 0);
    check("idle no accumulate", int'(frame_exact_sum), 0);

    // Randomized traffic, backpressure, restarts and occasional reset.
    for (int i = 0; i < 4000; i++) begin
      in_valid    = ($urandom_range(0, 3) != 0);
      out_ready   = ($urandom_range(0, 3) != 0);
      frame_start = ($urandom_range(0, 19) == 0);
      in_sum      = 1'($urandom);
      in_carry    = 1'($urandom);
      in_cout1    = 1'($urandom);
      in_cout2    = 1'($urandom);
      in_u_err    = 3'($urandom);
      rst_n       = ($urandom_range(0, 499) != 0);
      @(posedge clk); #1;
    end
    rst_n = 1'b1; in_valid = 1'b0; frame_start = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
